// File: rtl/irq_sequencer.sv
// Interrupt/reset arbiter: picks RESET/NMI/IRQ/BRK at an opcode-fetch boundary and drives
// the vector, source, B-flag and write-suppress for the shared BRK microsequence.
module irq_sequencer #(
  parameter int unsigned SYNC_STAGES = 2,
  parameter logic [15:0] NMI_VEC     = 16'hFFFA,
  parameter logic [15:0] RST_VEC     = 16'hFFFC,
  parameter logic [15:0] IRQ_VEC     = 16'hFFFE
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_nmi_n,
  input  logic        i_irq_n,
  input  logic        i_flag_i,
  input  logic        i_sync,
  input  logic        i_brk_sw,
  input  logic        i_vec_fetch,
  output logic        o_force_brk,
  output logic [15:0] o_vector,
  output logic [1:0]  o_src,
  output logic        o_b_flag,
  output logic        o_no_write,
  output logic        o_busy,
  output logic        o_pending
);

  localparam int unsigned Stages = (SYNC_STAGES < 1) ? 1 : SYNC_STAGES;

  localparam logic [1:0] SrcBrk = 2'd0;
  localparam logic [1:0] SrcIrq = 2'd1;
  localparam logic [1:0] SrcNmi = 2'd2;
  localparam logic [1:0] SrcRst = 2'd3;

  typedef enum logic {StRun, StInject} state_e;

  state_e            state_q, state_d;
  logic [Stages-1:0] nmi_sync_q, nmi_sync_d;
  logic [Stages-1:0] irq_sync_q, irq_sync_d;
  logic              nmi_prev_q;
  logic              rst_pend_q, rst_pend_d;
  logic              nmi_pend_q, nmi_pend_d;
  logic [1:0]        src_q, src_d;
  logic [15:0]       vector_q, vector_d;
  logic              b_flag_q, b_flag_d;
  logic              no_write_q, no_write_d;
  logic              force_brk;
  logic              nmi_synced, irq_synced;
  logic              nmi_edge, irq_ok, eligible;

  if (Stages == 1) begin : g_sync_one
    assign nmi_sync_d = i_nmi_n;
    assign irq_sync_d = i_irq_n;
  end else begin : g_sync_chain
    assign nmi_sync_d = {nmi_sync_q[Stages-2:0], i_nmi_n};
    assign irq_sync_d = {irq_sync_q[Stages-2:0], i_irq_n};
  end

  assign nmi_synced = nmi_sync_q[Stages-1];
  assign irq_synced = irq_sync_q[Stages-1];
  assign nmi_edge   = nmi_prev_q & ~nmi_synced;
  assign irq_ok     = ~irq_synced & ~i_flag_i;
  assign eligible   = rst_pend_q | nmi_pend_q | irq_ok;

  always_comb begin
    state_d    = state_q;
    rst_pend_d = rst_pend_q;
    nmi_pend_d = nmi_pend_q;
    src_d      = src_q;
    vector_d   = vector_q;
    b_flag_d   = b_flag_q;
    no_write_d = no_write_q;
    force_brk  = 1'b0;

    case (state_q)
      StRun: begin
        if (i_sync && eligible) begin
          force_brk = 1'b1;
          state_d   = StInject;
          b_flag_d  = 1'b0;
          if (rst_pend_q) begin
            src_d      = SrcRst;
            vector_d   = RST_VEC;
            no_write_d = 1'b1;
          end else if (nmi_pend_q) begin
            src_d      = SrcNmi;
            vector_d   = NMI_VEC;
            no_write_d = 1'b0;
          end else begin
            src_d      = SrcIrq;
            vector_d   = IRQ_VEC;
            no_write_d = 1'b0;
          end
        end else if (i_brk_sw) begin
          state_d    = StInject;
          src_d      = SrcBrk;
          vector_d   = IRQ_VEC;
          b_flag_d   = 1'b1;
          no_write_d = 1'b0;
        end
      end
      StInject: begin
        if (i_vec_fetch) begin
          state_d = StRun;
          if (src_q == SrcRst) rst_pend_d = 1'b0;
          if (src_q == SrcNmi) nmi_pend_d = 1'b0;
        end else if (nmi_pend_q && (src_q == SrcBrk || src_q == SrcIrq)) begin
          // NMI hijacks a BRK/IRQ sequence; B keeps its value so BRK still pushes B=1.
          src_d    = SrcNmi;
          vector_d = NMI_VEC;
        end
      end
      default: state_d = StRun;
    endcase

    // A fresh edge beats a clear in the same cycle.
    if (nmi_edge) nmi_pend_d = 1'b1;
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q    <= StRun;
      nmi_sync_q <= '1;
      irq_sync_q <= '1;
      nmi_prev_q <= 1'b1;
      rst_pend_q <= 1'b1;
      nmi_pend_q <= 1'b0;
      src_q      <= SrcRst;
      vector_q   <= RST_VEC;
      b_flag_q   <= 1'b0;
      no_write_q <= 1'b1;
    end else begin
      state_q    <= state_d;
      nmi_sync_q <= nmi_sync_d;
      irq_sync_q <= irq_sync_d;
      nmi_prev_q <= nmi_synced;
      rst_pend_q <= rst_pend_d;
      nmi_pend_q <= nmi_pend_d;
      src_q      <= src_d;
      vector_q   <= vector_d;
      b_flag_q   <= b_flag_d;
      no_write_q <= no_write_d;
    end
  end

  assign o_force_brk = force_brk;
  assign o_vector    = vector_q;
  assign o_src       = src_q;
  assign o_b_flag    = b_flag_q;
  assign o_no_write  = no_write_q;
  assign o_busy      = (state_q == StInject);
  assign o_pending   = eligible;

endmodule

// File: tb/tb_irq_sequencer.sv
// Bench for irq_sequencer: directed scenarios then random traffic, every cycle compared against
// a behavioural model of the arbitration rules.
module tb_irq_sequencer;

  localparam int S = 2;

  logic        i_clk = 1'b0;
  logic        i_rst, i_nmi_n, i_irq_n, i_flag_i, i_sync, i_brk_sw, i_vec_fetch;
  logic        o_force_brk, o_b_flag, o_no_write, o_busy, o_pending;
  logic [15:0] o_vector;
  logic [1:0]  o_src;

  int checks = 0;
  int errors = 0;

  irq_sequencer dut (
    .i_clk       (i_clk),
    .i_rst       (i_rst),
    .i_nmi_n     (i_nmi_n),
    .i_irq_n     (i_irq_n),
    .i_flag_i    (i_flag_i),
    .i_sync      (i_sync),
    .i_brk_sw    (i_brk_sw),
    .i_vec_fetch (i_vec_fetch),
    .o_force_brk (o_force_brk),
    .o_vector    (o_vector),
    .o_src       (o_src),
    .o_b_flag    (o_b_flag),
    .o_no_write  (o_no_write),
    .o_busy      (o_busy),
    .o_pending   (o_pending)
  );

  always #5 i_clk = ~i_clk;

  // Reference model: pin histories, pending flags and the active sequence.
  logic       mq[$];
  logic       iq[$];
  logic       m_nmi_prev, m_rst_pend, m_nmi_pend, m_inject, m_b;
  logic [1:0] m_src;

  function automatic logic [15:0] vec_of(input logic [1:0] src);
    case (src)
      2'd2:    return 16'hFFFA;
      2'd3:    return 16'hFFFC;
      default: return 16'hFFFE;
    endcase
  endfunction

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    mq = {};
    iq = {};
    for (int i = 0; i < S; i++) begin
      mq.push_back(1'b1);
      iq.push_back(1'b1);
    end
    m_nmi_prev = 1'b1;
    m_rst_pend = 1'b1;
    m_nmi_pend = 1'b0;
    m_inject   = 1'b0;
    m_src      = 2'd3;
    m_b        = 1'b0;
  endtask

  task automatic model_update();
    logic edge_seen, irq_ok;
    if (i_rst) begin
      model_reset();
      return;
    end
    edge_seen = m_nmi_prev && !mq[0];
    irq_ok    = !iq[0] && !i_flag_i;
    if (!m_inject) begin
      if (i_sync && (m_rst_pend || m_nmi_pend || irq_ok)) begin
        m_src    = m_rst_pend ? 2'd3 : (m_nmi_pend ? 2'd2 : 2'd1);
        m_b      = 1'b0;
        m_inject = 1'b1;
      end else if (i_brk_sw) begin
        m_src    = 2'd0;
        m_b      = 1'b1;
        m_inject = 1'b1;
      end
    end else if (i_vec_fetch) begin
      if (m_src == 2'd3) m_rst_pend = 1'b0;
      if (m_src == 2'd2) m_nmi_pend = 1'b0;
      m_inject = 1'b0;
    end else if (m_nmi_pend && m_src < 2'd2) begin
      m_src = 2'd2;
    end
    if (edge_seen) m_nmi_pend = 1'b1;
    m_nmi_prev = mq[0];
    mq.push_back(i_nmi_n);
    void'(mq.pop_front());
    iq.push_back(i_irq_n);
    void'(iq.pop_front());
  endtask

  // Compare all outputs mid-cycle, then advance model and DUT by one edge.
  task automatic step();
    logic elig;
    @(negedge i_clk);
    elig = m_rst_pend || m_nmi_pend || (!iq[0] && !i_flag_i);
    chk("force",    o_force_brk, i_sync && elig && !m_inject);
    chk("pending",  o_pending,   elig);
    chk("busy",     o_busy,      m_inject);
    chk("src",      o_src,       m_src);
    chk("vector",   o_vector,    vec_of(m_src));
    chk("b_flag",   o_b_flag,    m_b);
    chk("no_write", o_no_write,  m_src == 2'd3);
    @(posedge i_clk);
    model_update();
    #1;
  endtask

  task automatic steps(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  initial begin
    i_rst = 1'b1; i_nmi_n = 1'b1; i_irq_n = 1'b1; i_flag_i = 1'b0;
    i_sync = 1'b0; i_brk_sw = 1'b0; i_vec_fetch = 1'b0;
    repeat (2) @(posedge i_clk);
    model_reset();
    #1;
    chk("rst_src", o_src, 2'd3);
    chk("rst_vector", o_vector, 16'hFFFC);
    chk("rst_no_write", o_no_write, 1'b1);
    chk("rst_busy", o_busy, 1'b0);
    step();

    // Reset sequence after release.
    i_rst = 1'b0;
    steps(2);
    i_sync = 1'b1; step();
    i_sync = 1'b0;
    chk("t1_src", o_src, 2'd3);
    chk("t1_vector", o_vector, 16'hFFFC);
    chk("t1_no_write", o_no_write, 1'b1);
    chk("t1_busy", o_busy, 1'b1);
    i_vec_fetch = 1'b1; step();
    i_vec_fetch = 1'b0;
    chk("t1_idle", o_busy, 1'b0);
    i_sync = 1'b1; step();
    chk("t1_noforce", o_force_brk, 1'b0);
    i_sync = 1'b0;

    // NMI edge, held-low pin must not retrigger; a toggle does.
    i_nmi_n = 1'b0; steps(4);
    i_sync = 1'b1; step();
    i_sync = 1'b0;
    chk("t2_src", o_src, 2'd2);
    chk("t2_vector", o_vector, 16'hFFFA);
    i_vec_fetch = 1'b1; step();
    i_vec_fetch = 1'b0; steps(2);
    i_sync = 1'b1; step();
    chk("t2_noretrig", o_force_brk, 1'b0);
    i_sync = 1'b0;
    i_nmi_n = 1'b1; steps(3);
    i_nmi_n = 1'b0; steps(4);
    i_sync = 1'b1; step();
    i_sync = 1'b0;
    chk("t2_retrig", o_src, 2'd2);
    i_vec_fetch = 1'b1; step();
    i_vec_fetch = 1'b0;
    i_nmi_n = 1'b1;

    // Masked IRQ, then unmasked.
    i_irq_n = 1'b0; i_flag_i = 1'b1; steps(3);
    i_sync = 1'b1; step();
    chk("t3_masked", o_busy, 1'b0);
    i_flag_i = 1'b0; step();
    i_sync = 1'b0;
    chk("t3_src", o_src, 2'd1);
    chk("t3_vector", o_vector, 16'hFFFE);
    chk("t3_b", o_b_flag, 1'b0);
    i_irq_n = 1'b1; i_vec_fetch = 1'b1; step();
    i_vec_fetch = 1'b0; steps(3);

    // Software BRK hijacked by NMI; B stays 1.
    i_brk_sw = 1'b1; step();
    i_brk_sw = 1'b0;
    chk("t4_src_brk", o_src, 2'd0);
    chk("t4_b_brk", o_b_flag, 1'b1);
    i_nmi_n = 1'b0; steps(5);
    chk("t4_src_nmi", o_src, 2'd2);
    chk("t4_vector", o_vector, 16'hFFFA);
    chk("t4_b_kept", o_b_flag, 1'b1);
    i_vec_fetch = 1'b1; step();
    i_vec_fetch = 1'b0; i_nmi_n = 1'b1; steps(3);

    // IRQ and NMI together: NMI first, IRQ next.
    i_irq_n = 1'b0; i_nmi_n = 1'b0; steps(4);
    i_sync = 1'b1; step();
    i_sync = 1'b0;
    chk("t5_nmi", o_src, 2'd2);
    i_vec_fetch = 1'b1; step();
    i_vec_fetch = 1'b0;
    i_sync = 1'b1; step();
    i_sync = 1'b0;
    chk("t5_irq", o_src, 2'd1);

    // Reset mid-sequence.
    i_rst = 1'b1; step();
    i_rst = 1'b0;
    chk("t6_src", o_src, 2'd3);
    chk("t6_busy", o_busy, 1'b0);
    chk("t6_vector", o_vector, 16'hFFFC);
    i_sync = 1'b1; step();
    i_sync = 1'b0;
    chk("t6_force_src", o_src, 2'd3);
    i_vec_fetch = 1'b1; step();
    i_vec_fetch = 1'b0; i_irq_n = 1'b1; i_nmi_n = 1'b1; steps(3);

    // Random traffic.
    for (int c = 0; c < 1500; c++) begin
      i_rst = ($urandom_range(0, 99) == 0);
      if ($urandom_range(0, 7) == 0) i_nmi_n = ~i_nmi_n;
      if ($urandom_range(0, 5) == 0) i_irq_n = ~i_irq_n;
      i_flag_i    = ($urandom_range(0, 3) == 0);
      i_sync      = ($urandom_range(0, 3) == 0);
      i_brk_sw    = ($urandom_range(0, 15) == 0);
      i_vec_fetch = ($urandom_range(0, 5) == 0);
      step();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/irq_sequencer.md
Name: irq_sequencer

Overview:
- Interrupt/reset arbiter and sequencer for the CPU core.
- Arbitrates RESET, NMI, IRQ and software BRK. At an opcode-fetch boundary, forces the decoder onto the BRK path (opcode 8'h00) and supplies the vector address, B-flag value and write-suppress for the shared BRK microsequence.
- Sits between the external interrupt pins and the opcode register feeding decode.

Parameters:
- SYNC_STAGES, 2, flops in the nmi_n/irq_n synchronizer chains (min 1)
- NMI_VEC, 16'hFFFA, NMI vector low-byte address
- RST_VEC, 16'hFFFC, reset vector low-byte address
- IRQ_VEC, 16'hFFFE, IRQ/BRK vector low-byte address

Ports:
- i_clk  in  1  clock
- i_rst  in  1  reset; synchronous, active-high; clock i_clk
- i_nmi_n  in  1  async NMI pin, active-low, edge-triggered
- i_irq_n  in  1  async IRQ pin, active-low, level
- i_flag_i  in  1  P[2] interrupt-disable flag
- i_sync  in  1  core is in the opcode-fetch (T1) cycle
- i_brk_sw  in  1  pulse: decoded software BRK (opcode 00, not forced) entering T2
- i_vec_fetch  in  1  pulse: BRK sequence is reading the vector low byte
- o_force_brk  out  1  replace fetched opcode with 8'h00 this cycle
- o_vector  out  16  vector address for current sequence
- o_src  out  2  0=BRK, 1=IRQ, 2=NMI, 3=RST
- o_b_flag  out  1  B value to push with P (1 only for software BRK)
- o_no_write  out  1  suppress stack writes (RESET sequence)
- o_busy  out  1  sequence in progress
- o_pending  out  1  any eligible request latched

Behaviour:
- Reset values: o_force_brk=0, o_vector=RST_VEC, o_src=3, o_b_flag=0, o_no_write=1, o_busy=0. Internally rst_pend=1, nmi_pend=0, sync chains=1, FSM=RUN.
- Synchronizers: SYNC_STAGES flops each, reset to 1.
- NMI edge: synced value 1 then 0 on consecutive cycles sets nmi_pend the next cycle.
- irq_ok = (synced irq_n==0) && !i_flag_i. Not latched; sampled only at i_sync.
- FSM RUN:
  - Eligible request = rst_pend | nmi_pend | irq_ok. o_pending mirrors it.
  - o_force_brk = i_sync && eligible && FSM==RUN. Combinational, same cycle.
  - On the force cycle, the next edge registers o_src by priority RST>NMI>IRQ, o_vector to match, o_b_flag=0, o_no_write=(src==RST). FSM->INJECT, o_busy=1.
  - i_brk_sw while RUN and not forcing: o_src=0, o_vector=IRQ_VEC, o_b_flag=1, o_no_write=0, FSM->INJECT.
- FSM INJECT:
  - Hijack: if nmi_pend && o_src in {0,1} before i_vec_fetch, next cycle o_src=2 and o_vector=NMI_VEC. o_b_flag is unchanged (BRK still pushes B=1).
  - On i_vec_fetch: clear rst_pend if src==3; clear nmi_pend if src==2. FSM->RUN, o_busy=0. o_vector/o_src hold their last values.
  - o_force_brk is 0 throughout INJECT.
  - i_brk_sw in INJECT is ignored.
- Boundary conditions:
  - New NMI edge on the same cycle nmi_pend is cleared: the set wins, so nmi_pend stays 1.
  - NMI edge together with i_vec_fetch on an IRQ sequence: no hijack; the NMI is serviced next.
  - IRQ deasserted before i_sync: not taken.
  - i_flag_i set: IRQ masked. NMI and RST are unmaskable.
  - i_rst mid-sequence: immediate return to reset values, rst_pend=1.
  - i_sync and i_vec_fetch both asserted: illegal; i_vec_fetch takes precedence.
- Latency:
  - Pin falling edge to nmi_pend: SYNC_STAGES+1 cycles.
  - Force decision: 0 cycles from i_sync.
  - Vector/src valid: 1 cycle after force.

Test Plan:
- Release i_rst, pulse i_sync at cycle 3 -> o_force_brk=1 that cycle; next cycle o_src=3, o_vector=16'hFFFC, o_no_write=1. i_vec_fetch -> o_busy=0, second i_sync gives no force.
- i_nmi_n 1->0 held low, then i_sync -> forced, o_src=2, o_vector=16'hFFFA. After i_vec_fetch, the still-low pin causes no retrigger; a 0->1->0 toggle retriggers.
- i_irq_n=0 with i_flag_i=1, i_sync -> no force. Clear i_flag_i, i_sync -> o_src=1, o_vector=16'hFFFE, o_b_flag=0.
- i_brk_sw, NMI edge arriving 2 cycles later (before i_vec_fetch) -> o_src 0->2, o_vector 16'hFFFE->16'hFFFA, o_b_flag stays 1.
- IRQ low and NMI edge both pending at i_sync -> o_src=2. After i_vec_fetch with i_flag_i=0, next i_sync -> o_src=1.
- Assert i_rst during INJECT(src=1) -> outputs return to reset values; next i_sync forces with o_src=3.
